// File: rtl/cmn_list_entry_release.sv
// cmn_list_entry_release: free/occupied state, free count and protocol error flags of the list allocator.
// Optional CMN_LIST_REL_BYPASS_EN makes a release visible on v_entry_free in its own cycle.
module cmn_list_entry_release #(
    parameter int ENTRY_NUM = 16,
    parameter int ALLOC_NUM = 4,
    parameter int REL_NUM   = 4,
    localparam int AWIDTH   = $clog2(ENTRY_NUM),
    localparam int CWIDTH   = $clog2(ENTRY_NUM + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [ALLOC_NUM-1:0]                 v_alloc_vld,
    input  logic [ALLOC_NUM-1:0][ENTRY_NUM-1:0]  v_alloc_idx_oh,
    input  logic [REL_NUM-1:0]                   v_rel_vld,
    input  logic [REL_NUM-1:0][AWIDTH-1:0]       v_rel_idx_bin,
    output logic [ENTRY_NUM-1:0]                 v_entry_free,
    output logic [CWIDTH-1:0]                    free_cnt,
    output logic                                 free_lt_req,
    output logic                                 err_dbl_rel,
    output logic                                 err_bad_alloc
);
    logic [ENTRY_NUM-1:0] free_q, free_d, rel_mask, alloc_mask, vis;
    logic [CWIDTH-1:0]    free_cnt_q, free_cnt_d;
    logic                 free_lt_req_q, free_lt_req_d;
    logic                 err_dbl_rel_q, err_dbl_rel_d, err_bad_alloc_q, err_bad_alloc_d;
    logic                 dbl_hit, bad_hit;

    always_comb begin
        rel_mask   = '0;
        alloc_mask = '0;
        dbl_hit    = 1'b0;
        bad_hit    = 1'b0;
        for (int i = 0; i < REL_NUM; i++) begin
            if (v_rel_vld[i]) begin
                if (32'(v_rel_idx_bin[i]) >= 32'(ENTRY_NUM)) begin
                    dbl_hit = 1'b1;
                end else begin
                    if (free_q[v_rel_idx_bin[i]] || rel_mask[v_rel_idx_bin[i]]) dbl_hit = 1'b1;
                    rel_mask[v_rel_idx_bin[i]] = 1'b1;
                end
            end
        end
`ifdef CMN_LIST_REL_BYPASS_EN
        vis = free_q | rel_mask;
`else
        vis = free_q;
`endif
        for (int i = 0; i < ALLOC_NUM; i++) begin
            if (v_alloc_vld[i]) begin
                if ($countones(v_alloc_idx_oh[i]) != 1 || |(v_alloc_idx_oh[i] & ~vis)
                    || |(v_alloc_idx_oh[i] & alloc_mask)) bad_hit = 1'b1;
                alloc_mask = alloc_mask | v_alloc_idx_oh[i];
            end
        end
`ifndef CMN_LIST_REL_BYPASS_EN
        // without bypass a same-cycle release is not yet grantable
        if (|(alloc_mask & rel_mask)) bad_hit = 1'b1;
`endif
        free_d          = flush ? '1 : (free_q | rel_mask) & ~alloc_mask;
        free_cnt_d      = CWIDTH'($countones(free_d));
        free_lt_req_d   = 32'(free_cnt_d) < 32'(ALLOC_NUM);
        err_dbl_rel_d   = err_dbl_rel_q | (dbl_hit & ~flush);
        err_bad_alloc_d = err_bad_alloc_q | (bad_hit & ~flush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_q          <= '1;
            free_cnt_q      <= CWIDTH'(ENTRY_NUM);
            free_lt_req_q   <= ENTRY_NUM < ALLOC_NUM;
            err_dbl_rel_q   <= 1'b0;
            err_bad_alloc_q <= 1'b0;
        end else begin
            free_q          <= free_d;
            free_cnt_q      <= free_cnt_d;
            free_lt_req_q   <= free_lt_req_d;
            err_dbl_rel_q   <= err_dbl_rel_d;
            err_bad_alloc_q <= err_bad_alloc_d;
        end
    end

    assign v_entry_free  = vis;
    assign free_cnt      = free_cnt_q;
    assign free_lt_req   = free_lt_req_q;
    assign err_dbl_rel   = err_dbl_rel_q;
    assign err_bad_alloc = err_bad_alloc_q;
endmodule

// File: tb/tb_cmn_list_entry_release.sv
// tb_cmn_list_entry_release: scoreboard bench; a reference model pushes expected state per cycle.
module tb_cmn_list_entry_release;
    localparam int E = 16, A = 4, R = 4;

    typedef struct packed {
        logic [E-1:0] fr;
        logic [4:0]   cnt;
        logic         lt, dbl, bad;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic [A-1:0]        alloc_vld = '0;
    logic [A-1:0][E-1:0] alloc_oh  = '0;
    logic [R-1:0]        rel_vld   = '0;
    logic [R-1:0][3:0]   rel_idx   = '0;
    logic [E-1:0] v_entry_free;
    logic [4:0]   free_cnt;
    logic         free_lt_req, err_dbl_rel, err_bad_alloc;

    int errors = 0, checks = 0;
    exp_t sb[$];
    logic [E-1:0] m_free = '1;
    logic m_dbl = 1'b0, m_bad = 1'b0;

    cmn_list_entry_release dut (
        .clk(clk), .rst(rst), .flush(flush),
        .v_alloc_vld(alloc_vld), .v_alloc_idx_oh(alloc_oh),
        .v_rel_vld(rel_vld), .v_rel_idx_bin(rel_idx),
        .v_entry_free(v_entry_free), .free_cnt(free_cnt), .free_lt_req(free_lt_req),
        .err_dbl_rel(err_dbl_rel), .err_bad_alloc(err_bad_alloc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        flush = 1'b0; alloc_vld = '0; alloc_oh = '0; rel_vld = '0; rel_idx = '0;
    endtask

    task automatic model_reset();
        m_free = '1; m_dbl = 1'b0; m_bad = 1'b0;
    endtask

    task automatic model_step();
        logic [E-1:0] rm, am, vis;
        exp_t e;
        rm = '0; am = '0;
        if (flush) m_free = '1;
        else begin
            for (int i = 0; i < R; i++)
                if (rel_vld[i]) begin
                    if (rm[rel_idx[i]] || m_free[rel_idx[i]]) m_dbl = 1'b1;
                    rm[rel_idx[i]] = 1'b1;
                end
            vis = m_free;
`ifdef CMN_LIST_REL_BYPASS_EN
            vis = vis | rm;
`endif
            for (int i = 0; i < A; i++)
                if (alloc_vld[i]) begin
                    if ($countones(alloc_oh[i]) != 1) m_bad = 1'b1;
                    if ((alloc_oh[i] & ~vis) != 0 || (alloc_oh[i] & am) != 0) m_bad = 1'b1;
`ifndef CMN_LIST_REL_BYPASS_EN
                    if ((alloc_oh[i] & rm) != 0) m_bad = 1'b1;
`endif
                    am = am | alloc_oh[i];
                end
            m_free = (m_free | rm) & ~am;
        end
        e.fr = m_free; e.cnt = 5'($countones(m_free)); e.lt = e.cnt < 5'(A);
        e.dbl = m_dbl; e.bad = m_bad;
        sb.push_back(e);
    endtask

    // drive current inputs for one clock, then compare against the scoreboard head
    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        idle();
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("sb_free", v_entry_free, e.fr);
        chk("sb_cnt", free_cnt, e.cnt);
        chk("sb_lt", free_lt_req, e.lt);
        chk("sb_dbl", err_dbl_rel, e.dbl);
        chk("sb_bad", err_bad_alloc, e.bad);
    endtask

    task automatic grant4(input logic [E-1:0] a, b, c, d);
        alloc_vld = 4'hF; alloc_oh[0] = a; alloc_oh[1] = b; alloc_oh[2] = c; alloc_oh[3] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        logic [E-1:0] used;
        int idx;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_free", v_entry_free, 16'hFFFF);
        chk("rst_cnt", free_cnt, 16);
        chk("rst_lt", free_lt_req, 0);
        chk("rst_errs", {err_dbl_rel, err_bad_alloc}, 0);
        @(negedge clk);
        rst = 1'b0;

        grant4(16'h8000, 16'h4000, 16'h2000, 16'h1000); cycle();
        chk("alloc4_free", v_entry_free, 16'h0FFF);
        chk("alloc4_cnt", free_cnt, 12);

        grant4(16'h0001, 16'h0002, 16'h0004, 16'h0008); cycle();
        grant4(16'h0010, 16'h0020, 16'h0040, 16'h0080); cycle();
        alloc_vld = 4'h3; alloc_oh[0] = 16'h0100; alloc_oh[1] = 16'h0200; cycle();
        chk("fill_cnt", free_cnt, 2);
        chk("fill_lt", free_lt_req, 1);

        rel_vld = 4'h3; rel_idx[0] = 4'd15; rel_idx[1] = 4'd3; cycle();
        chk("rel_cnt", free_cnt, 4);
        chk("rel_lt", free_lt_req, 0);
        chk("rel_free", v_entry_free, 16'h8C08);
        chk("rel_no_err", {err_dbl_rel, err_bad_alloc}, 0);

        rel_vld = 4'h1; rel_idx[0] = 4'd10; cycle();
        chk("dbl_free_hit", err_dbl_rel, 1);

        flush = 1'b1; grant4(16'h0001, 16'h0001, 16'h0003, 16'h0000);
        rel_vld = 4'h3; rel_idx[0] = 4'd2; rel_idx[1] = 4'd2; cycle();
        chk("flush_free", v_entry_free, 16'hFFFF);
        chk("flush_cnt", free_cnt, 16);
        chk("flush_keep_dbl", err_dbl_rel, 1);
        chk("flush_no_bad", err_bad_alloc, 0);

        // async reset in the middle of a burst
        grant4(16'h0001, 16'h0002, 16'h0004, 16'h0008); cycle();
        grant4(16'h0010, 16'h0020, 16'h0040, 16'h0080);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_free", v_entry_free, 16'hFFFF);
        chk("arst_cnt", free_cnt, 16);
        chk("arst_errs", {err_dbl_rel, err_bad_alloc}, 0);
        rst = 1'b0;
        idle();
        model_reset();
        @(negedge clk);

        alloc_vld = 4'h1; alloc_oh[0] = 16'h0080; cycle();
        rel_vld = 4'h3; rel_idx[0] = 4'd7; rel_idx[1] = 4'd7; cycle();
        chk("dup_dbl", err_dbl_rel, 1);
        chk("dup_free7", v_entry_free[7], 1);
        rel_vld = 4'h1; rel_idx[0] = 4'd5; cycle();
        flush = 1'b1; cycle();
        chk("dbl_after_flush", err_dbl_rel, 1);

        do_reset();
        alloc_vld = 4'h1; alloc_oh[0] = 16'h0003; cycle();
        chk("twohot_bad", err_bad_alloc, 1);
        chk("twohot_mask", v_entry_free, 16'hFFFC);

        do_reset();
        alloc_vld = 4'h1; alloc_oh[0] = 16'h0001; cycle();
        alloc_vld = 4'h1; alloc_oh[0] = 16'h0001; cycle();
        chk("occ_bad", err_bad_alloc, 1);

        do_reset();
        alloc_vld = 4'h1; alloc_oh[0] = 16'h0004; cycle();
        rel_vld = 4'h1; rel_idx[0] = 4'd2; alloc_vld = 4'h1; alloc_oh[0] = 16'h0004; cycle();
        chk("relgnt_occ", v_entry_free[2], 0);

        do_reset();
        alloc_vld = 4'h3; alloc_oh[0] = 16'h0010; alloc_oh[1] = 16'h0010; cycle();
        chk("shared_bad", err_bad_alloc, 1);

        // random mostly-legal traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            used = '0;
            for (int i = 0; i < R; i++)
                if ($urandom_range(0, 2) == 0) begin
                    idx = $urandom_range(0, E - 1);
                    for (int t = 0; t < 20 && (m_free[idx] || used[idx]); t++) idx = $urandom_range(0, E - 1);
                    if (!m_free[idx] && !used[idx]) begin
                        rel_vld[i] = 1'b1; rel_idx[i] = 4'(idx); used[idx] = 1'b1;
                    end
                end
            for (int i = 0; i < A; i++)
                if ($urandom_range(0, 2) == 0) begin
                    idx = $urandom_range(0, E - 1);
                    for (int t = 0; t < 20 && (!m_free[idx] || used[idx]); t++) idx = $urandom_range(0, E - 1);
                    if (m_free[idx] && !used[idx]) begin
                        alloc_vld[i] = 1'b1; alloc_oh[i] = 16'(1) << idx; used[idx] = 1'b1;
                    end
                end
            if ($urandom_range(0, 59) == 0) begin
                alloc_vld[0] = 1'b1; alloc_oh[0] = 16'($urandom);
            end
            if ($urandom_range(0, 59) == 0) begin
                rel_vld[3] = 1'b1; rel_idx[3] = 4'($urandom_range(0, E - 1));
            end
            flush = $urandom_range(0, 39) == 0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
